// File: rtl/sobel_edge_stream_if.sv
// Pixel stream bundle for sobel_edge_stream: frame control and input pixels from the
// source, edge results and frame status back to the frame store.
interface sobel_edge_stream_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic [PIX_W-1:0]  in_pixel;
  logic [PIX_W-1:0]  threshold;
  logic              busy;
  logic              out_valid;
  logic [PIX_W-1:0]  out_pixel;
  logic [ADDR_W-1:0] out_addr;
  logic              frame_done;

  modport master (
    output start, in_valid, in_pixel, threshold,
    input  busy, out_valid, out_pixel, out_addr, frame_done
  );

  modport slave (
    input  start, in_valid, in_pixel, threshold,
    output busy, out_valid, out_pixel, out_addr, frame_done
  );
endinterface

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector with internal line buffering, one result per pixel.
// Define SOBEL_MAG_OUT_EN for a saturated grey-level edge map instead of a binary one.
module sobel_edge_stream #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic rst,
  sobel_edge_stream_if.slave bus
);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int SR_LEN = 2 * IMG_W + 3;
  localparam int SW     = PIX_W + 4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] FIRST_CEN = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] FLUSH_LEN = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(IMG_H - 1);
  localparam logic [SW-1:0]     PIX_MAX   = SW'({PIX_W{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic              accept, flush_adv, advance, emit;
  logic [ADDR_W-1:0] pix_cnt, flush_cnt;
  logic [ADDR_W-1:0] cen_addr, cen_col, cen_row;

  logic [PIX_W-1:0]  win_sr [SR_LEN];
  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              border_p0;

  logic signed [SW-1:0] gx_p0, gy_p0;
  logic [SW-1:0]        mag_p0;

  logic              out_valid_q, frame_done_q;
  logic [PIX_W-1:0]  out_pixel_q;
  logic [ADDR_W-1:0] out_addr_q;

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  function automatic logic [SW-1:0] abs_val(input logic signed [SW-1:0] v);
    return v[SW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [PIX_W-1:0] edge_value(input logic [SW-1:0] mag,
                                                  input logic [PIX_W-1:0] thr,
                                                  input logic border);
    logic [PIX_W-1:0] res;
    res = '0;
    if (!border && (mag > SW'(thr))) begin
`ifdef SOBEL_MAG_OUT_EN
      res = (mag > PIX_MAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
`else
      res = {PIX_W{1'b1}};
`endif
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Frame-done ends FLUSH so busy drops the cycle after the last result.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    flush_adv = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        accept = bus.in_valid;
        if (accept && (pix_cnt == LAST_ADDR)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        flush_adv = (flush_cnt < FLUSH_LEN);
        if (frame_done_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign advance = accept | flush_adv;
  // A centre exists once the window's bottom-right pixel is IMG_W+1 past it.
  assign emit    = advance && ((state_q == S_FLUSH) || (pix_cnt >= FIRST_CEN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt   <= '0;
      flush_cnt <= '0;
      cen_addr  <= '0;
      cen_col   <= '0;
      cen_row   <= '0;
      vld_p0    <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && bus.start) begin
        pix_cnt   <= '0;
        flush_cnt <= '0;
        cen_addr  <= '0;
        cen_col   <= '0;
        cen_row   <= '0;
      end else begin
        if (accept)    pix_cnt   <= pix_cnt + 1'b1;
        if (flush_adv) flush_cnt <= flush_cnt + 1'b1;
        if (emit) begin
          cen_addr <= cen_addr + 1'b1;
          if (cen_col == LAST_COL) begin
            cen_col <= '0;
            cen_row <= cen_row + 1'b1;
          end else begin
            cen_col <= cen_col + 1'b1;
          end
        end
      end
      vld_p0 <= emit;
    end
  end

  // Stage p0: window shift register (two lines plus three pixels) and centre tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SR_LEN; i++) win_sr[i] <= '0;
    end else if (advance) begin
      win_sr[0] <= accept ? bus.in_pixel : '0;
      for (int i = 1; i < SR_LEN; i++) win_sr[i] <= win_sr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (emit) begin
      addr_p0   <= cen_addr;
      border_p0 <= (cen_row == '0) || (cen_row == LAST_ROW) ||
                   (cen_col == '0) || (cen_col == LAST_COL);
    end
  end

  // Taps: p9 is the newest pixel, p1 sits two lines and two pixels back.
  always_comb begin
    gx_p0 = (ext(win_sr[2*IMG_W]) + (ext(win_sr[IMG_W]) <<< 1) + ext(win_sr[0]))
          - (ext(win_sr[2*IMG_W+2]) + (ext(win_sr[IMG_W+2]) <<< 1) + ext(win_sr[2]));
    gy_p0 = (ext(win_sr[2]) + (ext(win_sr[1]) <<< 1) + ext(win_sr[0]))
          - (ext(win_sr[2*IMG_W+2]) + (ext(win_sr[2*IMG_W+1]) <<< 1) + ext(win_sr[2*IMG_W]));
    mag_p0 = abs_val(gx_p0) + abs_val(gy_p0);
  end

  // Stage p1: registered result; pixel and address hold between valid beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_pixel_q  <= '0;
      out_addr_q   <= '0;
    end else begin
      out_valid_q  <= vld_p0;
      frame_done_q <= vld_p0 && (addr_p0 == LAST_ADDR);
      if (vld_p0) begin
        out_pixel_q <= edge_value(mag_p0, bus.threshold, border_p0);
        out_addr_q  <= addr_p0;
      end
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_pixel  = out_pixel_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_edge_stream.sv
// Directed-plus-random bench for sobel_edge_stream against a 2-D image reference model.
module tb_sobel_edge_stream;
  localparam int PIX_W  = 8;
  localparam int IMG_W  = 16;
  localparam int IMG_H  = 16;
  localparam int ADDR_W = 8;
  localparam int N      = IMG_W * IMG_H;
  localparam int PMAX   = (1 << PIX_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int img [IMG_H][IMG_W];
  int acc_cyc [N];
  int mon_pix[$], mon_addr[$], mon_cyc[$], mon_fd[$];

  sobel_edge_stream_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus();

  sobel_edge_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      mon_pix.push_back(int'(bus.out_pixel));
      mon_addr.push_back(int'(bus.out_addr));
      mon_cyc.push_back(cyc);
      mon_fd.push_back(int'(bus.frame_done));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int model_px(input int r, input int c, input int thr);
    int gx, gy, mag;
    if (r == 0 || r == IMG_H-1 || c == 0 || c == IMG_W-1) return 0;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    mag = iabs(gx) + iabs(gy);
    if (mag <= thr) return 0;
`ifdef SOBEL_MAG_OUT_EN
    return (mag > PMAX) ? PMAX : mag;
`else
    return PMAX;
`endif
  endfunction

  task automatic fill_flat(input int v);
    for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = v;
  endtask

  task automatic fill_step(input int h);
    for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = (c >= 8) ? h : 0;
  endtask

  task automatic fill_random();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) img[r][c] = int'($urandom_range(PMAX));
  endtask

  // step_val >= 0 adds a direct check of the vertical-step rule: interior cols 7/8 = step_val.
  task automatic run_frame(input int thr, input int gap_pct, input int step_val, input string name);
    int idx, r, c, j, ecyc, n;
    bit seen;
    mon_pix.delete(); mon_addr.delete(); mon_cyc.delete(); mon_fd.delete();
    bus.threshold = PIX_W'(thr);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idx = 0;
    while (idx < N) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_pixel = PIX_W'(img[idx / IMG_W][idx % IMG_W]);
        acc_cyc[idx] = cyc;
        idx++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (bus.frame_done) seen = 1'b1;
    end
    chk({name, " frame_done_seen"}, int'(seen), 1);
    if (seen) begin
      chk({name, " busy_at_done"}, int'(bus.busy), 1);
      @(negedge clk);
      chk({name, " busy_after_done"}, int'(bus.busy), 0);
      chk({name, " valid_after_done"}, int'(bus.out_valid), 0);
      chk({name, " addr_hold"}, int'(bus.out_addr), N-1);
    end
    chk({name, " out_count"}, mon_pix.size(), N);
    n = (mon_pix.size() < N) ? mon_pix.size() : N;
    for (int k = 0; k < n; k++) begin
      r = k / IMG_W;
      c = k % IMG_W;
      j = k + IMG_W + 1;
      ecyc = (j < N) ? acc_cyc[j] + 2 : acc_cyc[N-1] + 3 + (j - N);
      chk($sformatf("%s addr[%0d]", name, k), mon_addr[k], k);
      chk($sformatf("%s pix[%0d]", name, k), mon_pix[k], model_px(r, c, thr));
      chk($sformatf("%s cycle[%0d]", name, k), mon_cyc[k], ecyc);
      chk($sformatf("%s done[%0d]", name, k), mon_fd[k], (k == N-1) ? 1 : 0);
      if (step_val >= 0)
        chk($sformatf("%s step_rule[%0d]", name, k), mon_pix[k],
            (r > 0 && r < IMG_H-1 && (c == 7 || c == 8)) ? step_val : 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.threshold = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset frame_done", int'(bus.frame_done), 0);
    chk("reset out_pixel", int'(bus.out_pixel), 0);
    chk("reset out_addr", int'(bus.out_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    fill_flat(100);
    run_frame(127, 0, 0, "flat");

    fill_step(200);
    run_frame(127, 0, 255, "step");

    fill_flat(0);
    img[5][5] = 255;
    run_frame(255, 0, -1, "impulse");
    chk("impulse neighbour", model_px(4, 4, 255), 255);

    fill_step(200);
    run_frame(127, 35, 255, "step_gaps");

    // Abort mid-frame after 40 accepted pixels.
    fill_random();
    bus.threshold = PIX_W'(200);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pixel = PIX_W'(img[i / IMG_W][i % IMG_W]);
      @(posedge clk); #1;
    end
    chk("pre_reset out_valid", int'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset out_valid", int'(bus.out_valid), 0);
    chk("mid_reset busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(int'($urandom_range(100, 600)) % 256, 0, -1, "after_reset");

    for (int f = 0; f < 3; f++) begin
      fill_random();
      run_frame(int'($urandom_range(PMAX)), int'($urandom_range(50)), -1, $sformatf("random%0d", f));
    end

`ifdef SOBEL_MAG_OUT_EN
    fill_step(50);
    run_frame(100, 20, 200, "mag_step");
    run_frame(250, 0, 0, "mag_step_hi_thr");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
